// File: rtl/downcounter_timer_pkg.sv
// Shared definitions for the downcounter_timer block and its sibling
// mod-13 up-counter: default data width and the FSM state encoding.
package downcounter_timer_pkg;

  // Default counter/data width, also used by the up-counter on the shared bus.
  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/downcounter_timer_tristate_driver.sv
// tristate_driver: WIDTH-wide bus driver. Drives data onto q while enable is
// high, releases the bus (all z) otherwise. Purely combinational, so the
// enable takes effect with no latency.
//
// Ports:
//   enable  in   1      drive enable
//   data    in   WIDTH  value to drive
//   q       out  WIDTH  data when enable=1, otherwise high impedance
module tristate_driver
  import downcounter_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);

  assign q = enable ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/downcounter_timer.sv
// downcounter_timer: loadable down-counter / cycle timer with one-shot and
// auto-reload modes. Counts from the loaded value to 0, pulses TC for one
// cycle per terminal count, and drives the count onto a shared tri-state bus.
//
// Ports:
//   Clock       in   1      rising-edge clock
//   Resetn      in   1      asynchronous active-low reset
//   Load        in   1      load D into count and reload register, go IDLE
//   D           in   WIDTH  load value
//   Start       in   1      begin/resume counting (IDLE or HOLD, count != 0)
//   Stop        in   1      pause counting (RUN only)
//   AutoReload  in   1      1 = periodic, 0 = one-shot (sampled at count==1)
//   Enable      in   1      output enable for Q
//   Q           out  WIDTH  count when Enable=1, otherwise z
//   TC          out  1      registered terminal-count pulse
//   Busy        out  1      state == RUN
//   Done        out  1      state == DONE
module downcounter_timer
  import downcounter_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Start,
  input  logic             Stop,
  input  logic             AutoReload,
  input  logic             Enable,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Busy,
  output logic             Done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] count_reg,  count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             tc_reg,     tc_next;

  // State and datapath registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      tc_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      tc_reg     <= tc_next;
    end
  end

  // Next-state and count logic. Priority: Load > Stop > Start.
  // TC defaults low so it only lasts the single cycle in which count is 0.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;

    if (Load) begin
      count_next  = D;
      reload_next = D;
      state_next  = IDLE;
    end else begin
      case (state_reg)
        IDLE, HOLD: begin
          // Stop outranks Start even though Stop alone does nothing here.
          if (!Stop && Start && (count_reg != '0)) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (Stop) begin
            // Pausing freezes the count; the pending decrement is skipped.
            state_next = HOLD;
          end else if (count_reg != '0) begin
            count_next = count_reg - ONE;
            if (count_reg == ONE) begin
              tc_next    = 1'b1;
              state_next = AutoReload ? RUN : DONE;
            end
          end else begin
            // Only reached in auto-reload: the zero cycle restarts the period.
            count_next = reload_reg;
          end
        end
        DONE: begin
          count_next = '0;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    if (state_reg == RUN) begin
      Busy = 1'b1;
    end
    if (state_reg == DONE) begin
      Done = 1'b1;
    end
  end

  assign TC = tc_reg;

  tristate_driver #(
    .WIDTH (WIDTH)
  ) u_q_driver (
    .enable (Enable),
    .data   (count_reg),
    .q      (Q)
  );

endmodule

// File: tb/tb_downcounter_timer.sv
// Self-checking bench for downcounter_timer. Expected outputs are pushed to a
// scoreboard queue as each stimulus is driven and popped when the DUT output
// is sampled 1 time unit after the clock edge. The Q bus has pull-ups, as a
// shared bus would, so a released bus reads all ones.
module tb_downcounter_timer;

  localparam int W = 4;

  logic         Clock      = 1'b0;
  logic         Resetn     = 1'b0;
  logic         Load       = 1'b0;
  logic [W-1:0] D          = '0;
  logic         Start      = 1'b0;
  logic         Stop       = 1'b0;
  logic         AutoReload = 1'b0;
  logic         Enable     = 1'b1;
  wire  [W-1:0] q_bus;
  logic         TC;
  logic         Busy;
  logic         Done;

  for (genvar gi = 0; gi < W; gi++) begin : g_pullup
    pullup (q_bus[gi]);
  end

  downcounter_timer #(
    .WIDTH (W)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Load       (Load),
    .D          (D),
    .Start      (Start),
    .Stop       (Stop),
    .AutoReload (AutoReload),
    .Enable     (Enable),
    .Q          (q_bus),
    .TC         (TC),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] q, input logic tc,
                            input logic busy, input logic done);
    exp_t e;
    e.tag  = tag;
    e.q    = q;
    e.tc   = tc;
    e.busy = busy;
    e.done = done;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    $display("%0t %s: q=%h tc=%b busy=%b done=%b", $time, e.tag, q_bus, TC, Busy, Done);
    check({e.tag, ".q"},    32'(q_bus), 32'(e.q));
    check({e.tag, ".tc"},   32'(TC),    32'(e.tc));
    check({e.tag, ".busy"}, 32'(Busy),  32'(e.busy));
    check({e.tag, ".done"}, 32'(Done),  32'(e.done));
  endtask

  // Drive one cycle of controls, record what must follow the next edge, check it.
  task automatic step(input logic ld, input logic [W-1:0] d, input logic st, input logic sp,
                      input string tag, input logic [W-1:0] q, input logic tc,
                      input logic busy, input logic done);
    Load  = ld;
    D     = d;
    Start = st;
    Stop  = sp;
    expect_out(tag, q, tc, busy, done);
    @(posedge Clock);
    #1;
    sample();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held, then released away from the clock edge.
    #12;
    expect_out("rst_hold", 4'h0, 1'b0, 1'b0, 1'b0);
    sample();
    @(posedge Clock);
    #4;
    Resetn = 1'b1;
    step(1'b0, 4'h0, 1'b0, 1'b0, "rst_rel", 4'h0, 1'b0, 1'b0, 1'b0);

    // Start with count 0 is ignored.
    step(1'b0, 4'h0, 1'b1, 1'b0, "start_zero", 4'h0, 1'b0, 1'b0, 1'b0);

    // One-shot from 5.
    AutoReload = 1'b0;
    step(1'b1, 4'h5, 1'b0, 1'b0, "os_load",  4'h5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, "os_start", 4'h5, 1'b0, 1'b1, 1'b0);
    for (int v = 4; v >= 1; v--)
      step(1'b0, 4'h0, 1'b0, 1'b0, "os_run", W'(v), 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, "os_tc", 4'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      step(1'b0, 4'h0, (i == 3), 1'b0, "os_done", 4'h0, 1'b0, 1'b0, 1'b1);

    // Auto-reload from 3: period 4, TC on each zero.
    AutoReload = 1'b1;
    step(1'b1, 4'h3, 1'b0, 1'b0, "ar_load",  4'h3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, "ar_start", 4'h3, 1'b0, 1'b1, 1'b0);
    repeat (2) begin
      for (int v = 2; v >= 1; v--)
        step(1'b0, 4'h0, 1'b0, 1'b0, "ar_run", W'(v), 1'b0, 1'b1, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0, "ar_tc",     4'h0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0, "ar_reload", 4'h3, 1'b0, 1'b1, 1'b0);
    end

    // AutoReload only matters at the count==1 cycle.
    AutoReload = 1'b0;
    step(1'b0, 4'h0, 1'b0, 1'b0, "ars_run", 4'h2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, "ars_run", 4'h1, 1'b0, 1'b1, 1'b0);
    AutoReload = 1'b1;
    step(1'b0, 4'h0, 1'b0, 1'b0, "ars_tc", 4'h0, 1'b1, 1'b1, 1'b0);
    AutoReload = 1'b0;
    step(1'b0, 4'h0, 1'b0, 1'b0, "ars_reload", 4'h3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, "ars_run",    4'h2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, "ars_run",    4'h1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, "ars_last",   4'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0, "ars_done",   4'h0, 1'b0, 1'b0, 1'b1);

    // Pause and resume.
    step(1'b1, 4'h9, 1'b0, 1'b0, "pr_load",  4'h9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, "pr_start", 4'h9, 1'b0, 1'b1, 1'b0);
    for (int v = 8; v >= 6; v--)
      step(1'b0, 4'h0, 1'b0, 1'b0, "pr_run", W'(v), 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1, "pr_stop", 4'h6, 1'b0, 1'b0, 1'b0);
    repeat (4)
      step(1'b0, 4'h0, 1'b0, 1'b0, "pr_hold", 4'h6, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, "pr_resume", 4'h6, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, "pr_run",    4'h5, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, "pr_run",    4'h4, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b1, "pr_both",   4'h4, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, "pr_resume", 4'h4, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, "pr_run",    4'h3, 1'b0, 1'b1, 1'b0);

    // Load outranks Start while running.
    step(1'b1, 4'h9, 1'b0, 1'b0, "pri_load9", 4'h9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, "pri_start", 4'h9, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, "pri_run",   4'h8, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, "pri_run",   4'h7, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'h2, 1'b1, 1'b0, "pri_ld_st", 4'h2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, "pri_idle",  4'h2, 1'b0, 1'b0, 1'b0);

    // Tri-state: disabled bus reads pulled-up ones while counting continues.
    step(1'b1, 4'h9, 1'b0, 1'b0, "ts_load",  4'h9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, "ts_start", 4'h9, 1'b0, 1'b1, 1'b0);
    Enable = 1'b0;
    #1;
    expect_out("ts_off_now", 4'hF, 1'b0, 1'b1, 1'b0);
    sample();
    repeat (3)
      step(1'b0, 4'h0, 1'b0, 1'b0, "ts_off", 4'hF, 1'b0, 1'b1, 1'b0);
    Enable = 1'b1;
    #1;
    expect_out("ts_on_now", 4'h6, 1'b0, 1'b1, 1'b0);
    sample();
    step(1'b0, 4'h0, 1'b0, 1'b0, "ts_run", 4'h5, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-run takes effect before the next edge.
    #3;
    Resetn = 1'b0;
    #1;
    expect_out("rst_async", 4'h0, 1'b0, 1'b0, 1'b0);
    sample();
    step(1'b0, 4'h0, 1'b0, 1'b0, "rst_async_hold", 4'h0, 1'b0, 1'b0, 1'b0);
    Resetn = 1'b1;
    step(1'b0, 4'h0, 1'b0, 1'b0, "rst_after", 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, "rst_start0", 4'h0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
